vram_text_writer: RTL and testbench

- Upstream producer for the 80x60 character-cell VRAM read by the VGA sync/display stage.
- Accepts text commands over a valid/ready handshake: put character, set cursor, newline, clear screen.
- Expands each ASCII code to an 8x8 glyph through a font ROM.
- Writes 72-bit cells `{color[7:0], glyph[63:0]}` into the two-bank VRAM. Bank 1 holds cells 0-1023; bank 2 holds cells 1024-4799.

---
 rtl/vga_text_pkg.sv | 42 ++++
 rtl/font_rom_8x8.sv | 39 +++
 rtl/vram_text_writer.sv | 178 +++++++++++++++++
 tb/tb_vram_text_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared types and geometry for the text-mode VRAM writer.
// Contents: screen geometry, command and FSM enums, the 72-bit cell word
// and the flat cell-address helper (row*cols + col).
package vga_text_pkg;

    localparam int unsigned P_COLS        = 80;
    localparam int unsigned P_ROWS        = 60;
    localparam int unsigned P_BANK1_WORDS = 1024;
    localparam int unsigned P_CELLS       = P_COLS * P_ROWS;
    localparam int unsigned P_ADR_W       = 13;
    localparam int unsigned P_COL_W       = 7;
    localparam int unsigned P_ROW_W       = 6;
    localparam int unsigned P_COLOR_W     = 8;
    localparam int unsigned P_GLYPH_W     = 64;
    localparam int unsigned P_CELL_W      = P_COLOR_W + P_GLYPH_W;
    localparam int unsigned P_ROM_ADR_W   = 10;

    typedef enum logic [1:0] {
        CMD_PUT_CHAR   = 2'd0,
        CMD_SET_CURSOR = 2'd1,
        CMD_CLEAR      = 2'd2,
        CMD_NEWLINE    = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    typedef struct packed {
        logic [P_COLOR_W-1:0] color;
        logic [P_GLYPH_W-1:0] glyph;
    } cell_t;

    function automatic logic [P_ADR_W-1:0] cell_addr(input logic [P_COL_W-1:0] col,
                                                     input logic [P_ROW_W-1:0] row);
        return P_ADR_W'(row) * P_ADR_W'(P_COLS) + P_ADR_W'(col);
    endfunction

endpackage

// File: rtl/font_rom_8x8.sv
// 1024x8 synchronous font ROM, one cycle read latency.
// Ports: clk; i_adr = {ascii[6:0], line[2:0]}; o_data = glyph row, bit 7 leftmost.
// Only the digit codes 0x30-0x39 are populated; every other code reads 0.
module font_rom_8x8
    import vga_text_pkg::*;
(
    input  logic                   clk,
    input  logic [P_ROM_ADR_W-1:0] i_adr,
    output logic [7:0]             o_data
);

    logic [P_GLYPH_W-1:0] glyph;
    logic [7:0]           rom_byte;

    // Whole glyph per code, line 0 in the top byte.
    always_comb begin
        glyph = '0;
        case (i_adr[9:3])
            7'h30:   glyph = 64'h3C666E7666663C00;
            7'h31:   glyph = 64'h1838181818187E00;
            7'h32:   glyph = 64'h3C66060C30607E00;
            7'h33:   glyph = 64'h3C66061C06663C00;
            7'h34:   glyph = 64'h0C1C3C6C7E0C0C00;
            7'h35:   glyph = 64'h7E607C0606663C00;
            7'h36:   glyph = 64'h3C607C6666663C00;
            7'h37:   glyph = 64'h7E060C1830303000;
            7'h38:   glyph = 64'h3C66663C66663C00;
            7'h39:   glyph = 64'h3C66663E060C3800;
            default: glyph = '0;
        endcase
        // Line n sits at bits [63-8n -: 8]; shift by (7-n)*8.
        rom_byte = 8'(glyph >> {~i_adr[2:0], 3'b000});
    end

    always_ff @(posedge clk) begin
        o_data <= rom_byte;
    end

endmodule

// File: rtl/vram_text_writer.sv
// Text command front end for the 80x60 two-bank character VRAM.
// Ports: clk/rst (async, active-high); i_valid/o_ready command handshake with
// i_cmd, i_ascii, i_color, i_col, i_row; i_wr_allow gates VRAM writes;
// o_vram_wr_adr/o_vram_wr_data/o_vram_wr_en_1/o_vram_wr_en_2 VRAM write port;
// o_cur_col/o_cur_row cursor; o_err pulses on a rejected SET_CURSOR.
module vram_text_writer
    import vga_text_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_cmd,
    input  logic [7:0]           i_ascii,
    input  logic [P_COLOR_W-1:0] i_color,
    input  logic [P_COL_W-1:0]   i_col,
    input  logic [P_ROW_W-1:0]   i_row,
    input  logic                 i_wr_allow,
    output logic [P_ADR_W-1:0]   o_vram_wr_adr,
    output logic [P_CELL_W-1:0]  o_vram_wr_data,
    output logic                 o_vram_wr_en_1,
    output logic                 o_vram_wr_en_2,
    output logic [P_COL_W-1:0]   o_cur_col,
    output logic [P_ROW_W-1:0]   o_cur_row,
    output logic                 o_err
);

    state_e                 state_q;
    logic [6:0]             ascii_q;
    logic [P_COLOR_W-1:0]   color_q;
    logic [P_ADR_W-1:0]     cell_adr_q;
    logic [P_ADR_W-1:0]     clr_adr_q;
    logic [3:0]             line_q;
    logic [P_GLYPH_W-1:0]   glyph_q;
    logic [P_COL_W-1:0]     col_q;
    logic [P_ROW_W-1:0]     row_q;
    logic                   err_q;
    logic [P_ADR_W-1:0]     last_adr_q;
    cell_t                  last_data_q;

    logic [P_COL_W-1:0]     col_d;
    logic [P_ROW_W-1:0]     row_d;
    logic [P_ROW_W-1:0]     row_nl_d;
    logic [7:0]             rom_data;
    logic                   wr_fire;
    logic                   wr_bank1;
    logic [P_ADR_W-1:0]     wr_adr;
    cell_t                  wr_data;
    logic                   unused_ascii_msb;

    assign unused_ascii_msb = i_ascii[7];

    font_rom_8x8 u_font_rom (
        .clk    (clk),
        .i_adr  ({ascii_q, line_q[2:0]}),
        .o_data (rom_data)
    );

    // Cursor after a character write, and row after a newline.
    always_comb begin
        row_nl_d = (row_q == P_ROW_W'(P_ROWS - 1)) ? '0 : row_q + 1'b1;
        col_d    = col_q + 1'b1;
        row_d    = row_q;
        if (col_q == P_COL_W'(P_COLS - 1)) begin
            col_d = '0;
            row_d = row_nl_d;
        end
    end

    // Write port: the strobe follows i_wr_allow in the same cycle so the
    // display side's permission is honoured exactly.
    always_comb begin
        wr_adr        = cell_adr_q;
        wr_data.color = color_q;
        wr_data.glyph = glyph_q;
        if (state_q == ST_CLEAR) begin
            wr_adr        = clr_adr_q;
            wr_data.glyph = '0;
        end
        wr_fire  = i_wr_allow && ((state_q == ST_WRITE) || (state_q == ST_CLEAR));
        wr_bank1 = (wr_adr < P_ADR_W'(P_BANK1_WORDS));
    end

    assign o_vram_wr_en_1 = wr_fire &  wr_bank1;
    assign o_vram_wr_en_2 = wr_fire & ~wr_bank1;
    assign o_vram_wr_adr  = wr_fire ? wr_adr : last_adr_q;
    assign o_vram_wr_data = wr_fire ? wr_data : last_data_q;
    assign o_ready        = (state_q == ST_IDLE);
    assign o_cur_col      = col_q;
    assign o_cur_row      = row_q;
    assign o_err          = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ascii_q     <= '0;
            color_q     <= '0;
            cell_adr_q  <= '0;
            clr_adr_q   <= '0;
            line_q      <= '0;
            glyph_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            last_adr_q  <= '0;
            last_data_q <= '0;
        end else begin
            err_q <= 1'b0;
            // Remember the last written word so the port holds it between strobes.
            if (wr_fire) begin
                last_adr_q  <= wr_adr;
                last_data_q <= wr_data;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        unique case (cmd_e'(i_cmd))
                            CMD_PUT_CHAR: begin
                                ascii_q    <= i_ascii[6:0];
                                color_q    <= i_color;
                                cell_adr_q <= cell_addr(col_q, row_q);
                                line_q     <= '0;
                                state_q    <= ST_FETCH;
                            end
                            CMD_SET_CURSOR: begin
                                if ((i_col < P_COL_W'(P_COLS)) && (i_row < P_ROW_W'(P_ROWS))) begin
                                    col_q <= i_col;
                                    row_q <= i_row;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                color_q   <= i_color;
                                clr_adr_q <= '0;
                                state_q   <= ST_CLEAR;
                            end
                            CMD_NEWLINE: begin
                                col_q <= '0;
                                row_q <= row_nl_d;
                            end
                        endcase
                    end
                end
                ST_FETCH: begin
                    // ROM data trails the address by one cycle: line n arrives
                    // while line_q == n+1, shifted in top row first.
                    if (line_q != 4'd0) begin
                        glyph_q <= {glyph_q[P_GLYPH_W-9:0], rom_data};
                    end
                    if (line_q == 4'd8) begin
                        state_q <= ST_WRITE;
                    end
                    line_q <= line_q + 1'b1;
                end
                ST_WRITE: begin
                    if (i_wr_allow) begin
                        col_q   <= col_d;
                        row_q   <= row_d;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (i_wr_allow) begin
                        if (clr_adr_q == P_ADR_W'(P_CELLS - 1)) begin
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            clr_adr_q <= clr_adr_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_text_writer.sv
// Self-checking bench for vram_text_writer: directed corner cases followed by
// randomized command streams, compared against a cursor/glyph reference model.
module tb_vram_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [1:0]  i_cmd = 2'd0;
    logic [7:0]  i_ascii = 8'd0;
    logic [7:0]  i_color = 8'd0;
    logic [6:0]  i_col = 7'd0;
    logic [5:0]  i_row = 6'd0;
    logic        i_wr_allow = 1'b0;
    logic        o_ready;
    logic [12:0] o_vram_wr_adr;
    logic [71:0] o_vram_wr_data;
    logic        o_vram_wr_en_1;
    logic        o_vram_wr_en_2;
    logic [6:0]  o_cur_col;
    logic [5:0]  o_cur_row;
    logic        o_err;

    vram_text_writer dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_cmd          (i_cmd),
        .i_ascii        (i_ascii),
        .i_color        (i_color),
        .i_col          (i_col),
        .i_row          (i_row),
        .i_wr_allow     (i_wr_allow),
        .o_vram_wr_adr  (o_vram_wr_adr),
        .o_vram_wr_data (o_vram_wr_data),
        .o_vram_wr_en_1 (o_vram_wr_en_1),
        .o_vram_wr_en_2 (o_vram_wr_en_2),
        .o_cur_col      (o_cur_col),
        .o_cur_row      (o_cur_row),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    // 0: always allowed, 1: random, 2: never, 3: toggle every cycle
    int allow_mode = 0;
    always @(posedge clk) begin
        #1;
        case (allow_mode)
            0:       i_wr_allow = 1'b1;
            1:       i_wr_allow = 1'($urandom_range(0, 1));
            2:       i_wr_allow = 1'b0;
            default: i_wr_allow = ~i_wr_allow;
        endcase
    end

    // Reference font: the digit glyphs, top row first, bit 7 leftmost.
    logic [63:0] digit_font [0:9] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
        64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
        64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
        64'h3C66663E060C3800
    };

    function automatic logic [63:0] ref_glyph(input logic [7:0] a);
        int code;
        code = int'(a & 8'h7F);
        if (code >= 'h30 && code <= 'h39) return digit_font[code - 'h30];
        return 64'h0;
    endfunction

    // Write monitor
    logic [12:0] mq_adr  [$];
    logic [71:0] mq_data [$];
    logic        mq_bank2[$];
    int viol_both = 0, viol_allow = 0, viol_bank = 0;

    always @(negedge clk) begin
        if (o_vram_wr_en_1 || o_vram_wr_en_2) begin
            mq_adr.push_back(o_vram_wr_adr);
            mq_data.push_back(o_vram_wr_data);
            mq_bank2.push_back(o_vram_wr_en_2);
            if (o_vram_wr_en_1 && o_vram_wr_en_2) viol_both++;
            if (!i_wr_allow) viol_allow++;
            if (o_vram_wr_en_1 != (o_vram_wr_adr < 13'd1024)) viol_bank++;
        end
    end

    int n_chk = 0, n_pass = 0;
    int m_col = 0, m_row = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_q();
        mq_adr.delete();
        mq_data.delete();
        mq_bank2.delete();
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 72'(o_cur_col), 72'(m_col));
        chk({tag, "_row"}, 72'(o_cur_row), 72'(m_row));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 72'(o_ready), 72'd1);
        chk({tag, "_en1"},   72'(o_vram_wr_en_1), 72'd0);
        chk({tag, "_en2"},   72'(o_vram_wr_en_2), 72'd0);
        chk({tag, "_adr"},   72'(o_vram_wr_adr), 72'd0);
        chk({tag, "_data"},  o_vram_wr_data, 72'd0);
        chk({tag, "_err"},   72'(o_err), 72'd0);
        chk_cursor(tag);
    endtask

    task automatic wait_ready(input int max_cyc);
        int n;
        n = 0;
        while (!o_ready && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("ready_within_bound", 72'(o_ready), 72'd1);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] c,
                        input logic [6:0] col, input logic [5:0] row);
        @(negedge clk);
        wait_ready(20000);
        i_cmd   = cmd;
        i_ascii = a;
        i_color = c;
        i_col   = col;
        i_row   = row;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Wait for the single write of a PUT_CHAR, compare it, then advance the model cursor.
    task automatic expect_put(input logic [12:0] exp_adr, input logic [71:0] exp_data,
                              input bit check_lat);
        int n;
        int pos;
        n = 0;
        while (mq_adr.size() == 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (check_lat) chk("put_latency_cycles", 72'(n), 72'd10);
        chk("put_strobe_count", 72'(mq_adr.size()), 72'd1);
        if (mq_adr.size() != 0) begin
            chk("put_adr",   72'(mq_adr[0]), 72'(exp_adr));
            chk("put_data",  mq_data[0], exp_data);
            chk("put_bank2", 72'(mq_bank2[0]), 72'(exp_adr >= 13'd1024));
        end
        pos   = (m_row * 80 + m_col + 1) % 4800;
        m_col = pos % 80;
        m_row = pos / 80;
        if (check_lat) begin
            @(negedge clk);
            chk("ready_cycle_11", 72'(o_ready), 72'd1);
        end else begin
            wait_ready(100);
        end
        chk_cursor("put_cursor");
    endtask

    task automatic put_char_check(input logic [7:0] a, input logic [7:0] c, input bit check_lat);
        logic [12:0] exp_adr;
        exp_adr = 13'(m_row * 80 + m_col);
        clear_q();
        send(2'd0, a, c, 7'd0, 6'd0);
        expect_put(exp_adr, {c, ref_glyph(a)}, check_lat);
    endtask

    task automatic set_cursor_check(input logic [6:0] col, input logic [5:0] row);
        logic exp_err;
        exp_err = (col >= 7'd80) || (row >= 6'd60);
        send(2'd1, 8'd0, 8'd0, col, row);
        @(negedge clk);
        chk("setcur_err", 72'(o_err), 72'(exp_err));
        if (!exp_err) begin
            m_col = int'(col);
            m_row = int'(row);
        end
        chk_cursor("setcur");
        @(negedge clk);
        chk("err_one_cycle", 72'(o_err), 72'd0);
    endtask

    task automatic newline_check();
        send(2'd3, 8'd0, 8'd0, 7'd0, 6'd0);
        @(negedge clk);
        m_col = 0;
        m_row = (m_row + 1) % 60;
        chk_cursor("newline");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int n;
        int sel;
        logic [7:0] a;
        logic [12:0] exp_adr;

        repeat (3) @(negedge clk);
        chk_reset("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("after_reset");

        // First character: timing and content
        allow_mode = 0;
        put_char_check(8'h31, 8'hE0, 1'b1);

        // Last cell and wrap to origin
        set_cursor_check(7'd79, 6'd59);
        put_char_check(8'h37, 8'h1C, 1'b0);
        set_cursor_check(7'd80, 6'd0);
        set_cursor_check(7'd0, 6'd60);

        // Bank split 1023 / 1024
        set_cursor_check(7'd63, 6'd12);
        put_char_check(8'h38, 8'h44, 1'b0);
        put_char_check(8'hB9, 8'h81, 1'b0);
        put_char_check(8'h41, 8'h22, 1'b0);

        set_cursor_check(7'd12, 6'd59);
        newline_check();
        newline_check();

        // Write held off by the display side
        set_cursor_check(7'd40, 6'd30);
        allow_mode = 2;
        exp_adr = 13'(m_row * 80 + m_col);
        clear_q();
        send(2'd0, 8'h35, 8'h5A, 7'd0, 6'd0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_vram_wr_en_1 || o_vram_wr_en_2) bad++;
            if (o_ready) bad++;
        end
        chk("stall_quiet", 72'(bad), 72'd0);
        allow_mode = 0;
        @(negedge clk);
        #1;
        chk("stall_first_allowed_strobe", 72'(o_vram_wr_en_1 | o_vram_wr_en_2), 72'd1);
        expect_put(exp_adr, {8'h5A, ref_glyph(8'h35)}, 1'b0);

        // Full clear with a toggling allow
        set_cursor_check(7'd10, 6'd20);
        allow_mode = 3;
        clear_q();
        send(2'd2, 8'h00, 8'h0F, 7'd0, 6'd0);
        wait_ready(12000);
        chk("clear_write_count", 72'(mq_adr.size()), 72'd4800);
        bad = 0;
        for (int i = 0; i < mq_adr.size(); i++) begin
            if (mq_adr[i] !== 13'(i) || mq_data[i] !== {8'h0F, 64'h0}) bad++;
        end
        chk("clear_sequence", 72'(bad), 72'd0);
        m_col = 0;
        m_row = 0;
        chk_cursor("clear_cursor");
        @(negedge clk);
        chk("adr_hold", 72'(o_vram_wr_adr), 72'd4799);
        chk("data_hold", o_vram_wr_data, {8'h0F, 64'h0});

        // Reset during glyph fetch
        allow_mode = 0;
        set_cursor_check(7'd5, 6'd5);
        send(2'd0, 8'h32, 8'hAA, 7'd0, 6'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        m_col = 0;
        m_row = 0;
        chk_reset("rst_in_fetch");
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (30) @(negedge clk);
        chk("rst_fetch_no_strobe", 72'(mq_adr.size()), 72'd0);

        // Reset during clear at cell 2000
        set_cursor_check(7'd7, 6'd3);
        clear_q();
        send(2'd2, 8'h00, 8'h33, 7'd0, 6'd0);
        n = 0;
        while (mq_adr.size() < 2001 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("clear_reached_2000", 72'(mq_adr.size()), 72'd2001);
        rst = 1'b1;
        #1;
        m_col = 0;
        m_row = 0;
        chk_reset("rst_in_clear");
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (30) @(negedge clk);
        chk("rst_clear_no_strobe", 72'(mq_adr.size()), 72'd0);

        // Random command stream with random write permission
        allow_mode = 1;
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 4) begin
                if ($urandom_range(0, 1) == 1)
                    a = 8'h30 + 8'($urandom_range(0, 9)) + (8'($urandom_range(0, 1)) << 7);
                else
                    a = 8'($urandom);
                put_char_check(a, 8'($urandom), 1'b0);
            end else if (sel < 6) begin
                set_cursor_check(7'($urandom_range(0, 127)), 6'($urandom_range(0, 63)));
            end else begin
                newline_check();
            end
        end

        chk("never_both_strobes", 72'(viol_both), 72'd0);
        chk("strobe_only_when_allowed", 72'(viol_allow), 72'd0);
        chk("strobe_matches_bank", 72'(viol_bank), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
